// File: rtl/uart_cmd_pkg.sv
// Shared command codes, TX state encoding and io_out8 bit map for uart_cmd_tx.
// Optional parity support is selected with UART_CMD_TX_PARITY_EN.
package uart_cmd_pkg;

  localparam logic [1:0] CMD_DATA   = 2'd0;
  localparam logic [1:0] CMD_CONFIG = 2'd1;
  localparam logic [1:0] CMD_PREDIV = 2'd2;
  localparam logic [1:0] CMD_SPARE  = 2'd3;

  localparam logic [4:0] CMD_CONFIG_RESET = 5'b11000;

  localparam int unsigned OUT_TXD     = 0;
  localparam int unsigned OUT_BUSY    = 1;
  localparam int unsigned OUT_FULL    = 2;
  localparam int unsigned OUT_EMPTY   = 3;
  localparam int unsigned OUT_OVF     = 4;
  localparam int unsigned OUT_LVL_LSB = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP1  = 3'd3,
`ifdef UART_CMD_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP2  = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO succeeds only when a pop
// happens in the same cycle.
module uart_cmd_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            push,
  input  logic                            pop,
  input  logic [DATA_W-1:0]               din,
  output logic [DATA_W-1:0]               dout,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    full    = (count == (AW+1)'(FIFO_DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr];
    level   = count;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// Command-driven framed UART transmitter with data FIFO and prescaler.
// Define UART_CMD_TX_PARITY_EN to add a configurable parity bit.
module uart_cmd_tx
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PREDIV_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] io_in7,
  input  logic       io_cmdStrobe,
  output logic [7:0] io_out8,
  output logic       io_resetCommandStrobe,
  output logic       io_gatedTxdStopBitSupport
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]          cmd;
  logic [4:0]          payload;
  logic                push_cmd, stage_cmd, rst_cmd, cfg_wr, pd_wr;
  logic [3:0]          staged_low;
  logic [7:0]          push_byte, prediv_wide, prediv_new;
  logic [PREDIV_W-1:0] prediv, cnt;
  logic                tx_en, stop2, stop2_q, overflow;
  logic                tick, start_frame, last_bit, txd, busy;
  logic [DATA_W-1:0]   fifo_dout, shreg;
  logic                fifo_full, fifo_empty;
  logic [LW-1:0]       fifo_level;
  logic [3:0]          lvl_wide;
  logic [2:0]          lvl_sat, bit_idx;
  tx_state_t           state, state_n;
`ifdef UART_CMD_TX_PARITY_EN
  logic                parity_en, odd, par_q;
`endif

  always_comb begin
    cmd       = io_in7[1:0];
    payload   = io_in7[6:2];
    push_cmd  = 1'b0;
    stage_cmd = 1'b0;
    rst_cmd   = 1'b0;
    cfg_wr    = 1'b0;
    pd_wr     = 1'b0;
    if (io_cmdStrobe) begin
      case (cmd)
        CMD_DATA:   begin push_cmd = payload[4]; stage_cmd = !payload[4]; end
        CMD_CONFIG: begin
          rst_cmd = (payload == CMD_CONFIG_RESET);
          cfg_wr  = !payload[4];
        end
        CMD_PREDIV: pd_wr = 1'b1;
        CMD_SPARE:  ;
      endcase
    end
    push_byte   = {payload[3:0], staged_low};
    prediv_wide = 8'(prediv);
    prediv_new  = payload[4] ? {payload[3:0], prediv_wide[3:0]}
                             : {prediv_wide[7:4], payload[3:0]};
  end

  uart_cmd_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (rst_cmd),
    .push  (push_cmd),
    .pop   (start_frame),
    .din   (push_byte[DATA_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    tick        = (cnt == '0);
    last_bit    = (bit_idx == 3'(DATA_W - 1));
    state_n     = state;
    start_frame = 1'b0;
    case (state)
      ST_IDLE: if (tx_en && !fifo_empty) begin
        state_n     = ST_START;
        start_frame = 1'b1;
      end
      ST_START: if (tick) state_n = ST_DATA;
`ifdef UART_CMD_TX_PARITY_EN
      ST_DATA:   if (tick && last_bit) state_n = parity_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (tick) state_n = ST_STOP1;
`else
      ST_DATA:   if (tick && last_bit) state_n = ST_STOP1;
`endif
      ST_STOP1: if (tick) state_n = stop2_q ? ST_STOP2 : ST_IDLE;
      ST_STOP2: if (tick) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    // The reset command overrides any transition, including a pending pop.
    if (rst_cmd) begin
      state_n     = ST_IDLE;
      start_frame = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      staged_low            <= '0;
      prediv                <= '0;
      tx_en                 <= 1'b1;
      stop2                 <= 1'b0;
      stop2_q               <= 1'b0;
      overflow              <= 1'b0;
      cnt                   <= '0;
      shreg                 <= '0;
      bit_idx               <= '0;
      io_resetCommandStrobe <= 1'b0;
`ifdef UART_CMD_TX_PARITY_EN
      parity_en             <= 1'b0;
      odd                   <= 1'b0;
      par_q                 <= 1'b0;
`endif
    end else begin
      io_resetCommandStrobe <= rst_cmd;
      if (stage_cmd) staged_low <= payload[3:0];
      if (pd_wr)     prediv     <= prediv_new[PREDIV_W-1:0];
      if (cfg_wr) begin
        stop2 <= payload[0];
        tx_en <= payload[1];
`ifdef UART_CMD_TX_PARITY_EN
        parity_en <= payload[2];
        odd       <= payload[3];
`endif
      end
      if (rst_cmd)                                  overflow <= 1'b0;
      else if (push_cmd && fifo_full && !start_frame) overflow <= 1'b1;
      if (state_n == ST_STOP1 && state != ST_STOP1) stop2_q <= stop2;
      if (start_frame) begin
        cnt     <= prediv;
        shreg   <= fifo_dout;
        bit_idx <= '0;
`ifdef UART_CMD_TX_PARITY_EN
        par_q   <= ^fifo_dout ^ odd;
`endif
      end else if (state != ST_IDLE) begin
        cnt <= tick ? prediv : cnt - PREDIV_W'(1);
        if (state == ST_DATA && tick) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    case (state)
      ST_START:  txd = 1'b0;
      ST_DATA:   txd = shreg[0];
`ifdef UART_CMD_TX_PARITY_EN
      ST_PARITY: txd = par_q;
`endif
      default:   txd = 1'b1;
    endcase
    busy     = (state != ST_IDLE);
    lvl_wide = 4'(fifo_level);
    lvl_sat  = (lvl_wide > 4'd7) ? 3'd7 : lvl_wide[2:0];
    io_gatedTxdStopBitSupport = (state == ST_STOP2);
    io_out8                   = '0;
    io_out8[OUT_TXD]          = txd;
    io_out8[OUT_BUSY]         = busy;
    io_out8[OUT_FULL]         = fifo_full;
    io_out8[OUT_EMPTY]        = fifo_empty;
    io_out8[OUT_OVF]          = overflow;
    io_out8[OUT_LVL_LSB +: 3] = lvl_sat;
  end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Directed self-checking bench for uart_cmd_tx (default parameters).
module tb_uart_cmd_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] io_in7;
  logic       io_cmdStrobe;
  logic [7:0] io_out8;
  logic       io_resetCommandStrobe;
  logic       io_gatedTxdStopBitSupport;

  int n_checks = 0;
  int n_pass   = 0;

  uart_cmd_tx #(.DATA_W(8), .FIFO_DEPTH(4), .PREDIV_W(8)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .io_in7                    (io_in7),
    .io_cmdStrobe              (io_cmdStrobe),
    .io_out8                   (io_out8),
    .io_resetCommandStrobe     (io_resetCommandStrobe),
    .io_gatedTxdStopBitSupport (io_gatedTxdStopBitSupport)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [1:0] cmd, input logic [4:0] pl);
    io_in7       = {pl, cmd};
    io_cmdStrobe = 1'b1;
    @(negedge clk);
    io_cmdStrobe = 1'b0;
    io_in7       = '0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    send(2'd0, {1'b0, b[3:0]});
    send(2'd0, {1'b1, b[7:4]});
  endtask

  initial begin
    logic [9:0]  seq_a5;
`ifdef UART_CMD_TX_PARITY_EN
    logic [10:0] seq_07;
`endif
    int zeros, gated, first_gated, bad;

    reset        = 1'b0;
    io_in7       = '0;
    io_cmdStrobe = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out8", io_out8, 8'h09);
    check("reset_rcs", {7'd0, io_resetCommandStrobe}, 8'h00);
    check("reset_gated", {7'd0, io_gatedTxdStopBitSupport}, 8'h00);
    reset = 1'b1;
    bad   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io_out8[0] !== 1'b1) bad++;
    end
    check("idle_txd_high", 8'(bad), 8'd0);
    check("idle_out8", io_out8, 8'h09);

    // prediv=0: byte A5 one bit per clock
    seq_a5 = 10'b1101001010;
    push_byte(8'hA5);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a5_txd_%0d", i), {7'd0, io_out8[0]}, {7'd0, seq_a5[i]});
      check($sformatf("a5_busy_%0d", i), {7'd0, io_out8[1]}, 8'h01);
      @(negedge clk);
    end
    check("a5_done_out8", io_out8, 8'h09);

    // prediv=3, stop2=1, byte 00
    send(2'd2, 5'b00011);
    send(2'd1, 5'b00011);
    push_byte(8'h00);
    @(negedge clk);
    zeros = 0; gated = 0; first_gated = -1; bad = 0;
    for (int i = 0; i < 44; i++) begin
      if (io_out8[0] === 1'b0) zeros++;
      if (io_gatedTxdStopBitSupport === 1'b1) begin
        gated++;
        if (first_gated < 0) first_gated = i;
      end
      if (io_out8[1] !== 1'b1) bad++;
      @(negedge clk);
    end
    check("p3_zero_clocks", 8'(zeros), 8'd36);
    check("p3_stop2_clocks", 8'(gated), 8'd4);
    check("p3_stop2_first", 8'(first_gated), 8'd40);
    check("p3_busy_all", 8'(bad), 8'd0);
    check("p3_done_out8", io_out8, 8'h09);
    check("p3_done_gated", {7'd0, io_gatedTxdStopBitSupport}, 8'h00);

    // tx_en=0, five pushes into a 4-deep FIFO
    send(2'd1, 5'b00000);
    for (int i = 0; i < 5; i++) push_byte(8'(8'h11 * i));
    check("ovf_out8", io_out8, 8'h95);
    repeat (5) @(negedge clk);
    check("ovf_hold_out8", io_out8, 8'h95);
    send(2'd1, 5'b11000);
    check("flush_rcs", {7'd0, io_resetCommandStrobe}, 8'h01);
    check("flush_out8", io_out8, 8'h09);
    @(negedge clk);
    check("flush_rcs_pulse", {7'd0, io_resetCommandStrobe}, 8'h00);

    // prediv=7, tx_en=1, reset command mid-data of byte FF
    send(2'd2, 5'b00111);
    send(2'd1, 5'b00010);
    push_byte(8'hFF);
    @(negedge clk);
    repeat (11) @(negedge clk);
    check("ff_mid_busy", {7'd0, io_out8[1]}, 8'h01);
    check("ff_mid_txd", {7'd0, io_out8[0]}, 8'h01);
    check("ff_mid_empty", {7'd0, io_out8[3]}, 8'h01);
    send(2'd1, 5'b11000);
    check("rstcmd_rcs", {7'd0, io_resetCommandStrobe}, 8'h01);
    check("rstcmd_out8", io_out8, 8'h09);
    @(negedge clk);
    check("rstcmd_rcs_pulse", {7'd0, io_resetCommandStrobe}, 8'h00);
    check("rstcmd_out8_after", io_out8, 8'h09);

    // hardware reset mid-frame
    push_byte(8'h3C);
    repeat (5) @(negedge clk);
    check("hwrst_pre_busy", {7'd0, io_out8[1]}, 8'h01);
    check("hwrst_pre_txd", {7'd0, io_out8[0]}, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("hwrst_out8", io_out8, 8'h09);
    repeat (3) @(negedge clk);
    check("hwrst_out8_after", io_out8, 8'h09);

`ifdef UART_CMD_TX_PARITY_EN
    // parity_en=1, odd=0, prediv=0 after reset, byte 07
    seq_07 = 11'b11000001110;
    send(2'd1, 5'b00110);
    push_byte(8'h07);
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("par_txd_%0d", i), {7'd0, io_out8[0]}, {7'd0, seq_07[i]});
      check($sformatf("par_busy_%0d", i), {7'd0, io_out8[1]}, 8'h01);
      @(negedge clk);
    end
    check("par_done_out8", io_out8, 8'h09);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
